// File: rtl/riscv_pkg.sv
// Shared pipeline-control types: hazard FSM states, operand-forward selects
// and the register-match helper used by the forwarding and hazard logic.
package riscv_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      MWAIT  = 2'd2
   } state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // x0 is hard-wired to zero, so it can never produce or consume a hazard.
   function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd, input logic wr);
      return wr && (rs != 5'd0) && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Data-memory handshake between the MEM stage and data memory.
// dmem_req is held high by the MEM stage while it needs memory; the access
// completes in the cycle dmem_ack is sampled high (same cycle = zero wait).
interface hazard_ctrl_if;
   logic dmem_req;
   logic dmem_ack;

   modport master  (output dmem_req, input  dmem_ack);
   modport slave   (input  dmem_req, output dmem_ack);
   modport monitor (input  dmem_req, input  dmem_ack);
endinterface

// File: rtl/fwd_unit.sv
// Per-operand forward select: MEM result beats WB result, register file otherwise.
module fwd_unit
   import riscv_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_wr,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_wr,
   output logic [1:0] fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      if (reg_match(rs, mem_rd, mem_reg_wr)) begin
         fwd_sel = FWD_MEM;
      end else if (reg_match(rs, wb_rd, wb_reg_wr)) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use bubble, memory-wait stall, branch flush.
// Define FORWARDING_EN to forward from MEM/WB; without it every RAW match stalls until it drains.
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int MWAIT_MAX = 255,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_wr,
   input  logic             ex_is_load,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_wr,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_wr,
   input  logic             br_taken,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err_timeout,
   output state_e           dbg_state
);

   localparam int WCW = $clog2(MWAIT_MAX + 1);
   localparam logic [WCW-1:0] WAIT_LIM = WCW'(MWAIT_MAX);

   state_e           state_q, state_d;
   logic [WCW-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic       stall_fe, stall_be, flush_id_c, flush_ex_c;
   logic       hazard, mem_wait;
   logic [1:0] fwd_a_c, fwd_b_c;

   fwd_unit u_fwd_a (
      .rs         (id_rs1),
      .mem_rd     (mem_rd),
      .mem_reg_wr (mem_reg_wr),
      .wb_rd      (wb_rd),
      .wb_reg_wr  (wb_reg_wr),
      .fwd_sel    (fwd_a_c)
   );

   fwd_unit u_fwd_b (
      .rs         (id_rs2),
      .mem_rd     (mem_rd),
      .mem_reg_wr (mem_reg_wr),
      .wb_rd      (wb_rd),
      .wb_reg_wr  (wb_reg_wr),
      .fwd_sel    (fwd_b_c)
   );

   assign mem_wait = dmem_req & ~dmem_ack;

`ifdef FORWARDING_EN
   // Only a load in EX cannot be forwarded in time; everything else is bypassed.
   assign hazard = reg_match(id_rs1, ex_rd, ex_is_load) | reg_match(id_rs2, ex_rd, ex_is_load);
   assign fwd_a  = rst_n ? fwd_a_c : FWD_RF;
   assign fwd_b  = rst_n ? fwd_b_c : FWD_RF;
`else
   // A forward-select hit is reused as the MEM/WB RAW detector; a load always writes.
   assign hazard = reg_match(id_rs1, ex_rd, ex_reg_wr | ex_is_load)
                 | reg_match(id_rs2, ex_rd, ex_reg_wr | ex_is_load)
                 | (fwd_a_c != FWD_RF) | (fwd_b_c != FWD_RF);
   assign fwd_a  = FWD_RF;
   assign fwd_b  = FWD_RF;
`endif

   always_comb begin
      state_d    = state_q;
      stall_fe   = 1'b0;
      stall_be   = 1'b0;
      flush_id_c = 1'b0;
      flush_ex_c = 1'b0;
      case (state_q)
         RUN: begin
            flush_id_c = br_taken;
            flush_ex_c = br_taken;
            if (mem_wait) begin
               state_d = MWAIT;
            end else if (hazard && !br_taken) begin
               stall_fe   = 1'b1;
               flush_ex_c = 1'b1;
`ifdef FORWARDING_EN
               state_d    = LSTALL;
`endif
            end
         end
         LSTALL: begin
            flush_id_c = br_taken;
            flush_ex_c = br_taken;
            state_d    = RUN;
         end
         MWAIT: begin
            stall_fe = 1'b1;
            stall_be = 1'b1;
            if (dmem_ack) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   assign stall_if  = rst_n & stall_fe;
   assign stall_id  = rst_n & stall_fe;
   assign stall_ex  = rst_n & stall_be;
   assign stall_mem = rst_n & stall_be;
   assign flush_id  = rst_n & flush_id_c;
   assign flush_ex  = rst_n & flush_ex_c;

   // wait_q holds the number of MWAIT cycles already completed in this wait.
   always_comb begin
      wait_d = '0;
      if (state_q == MWAIT && state_d == MWAIT) begin
         wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + 1'b1;
      end
      err_d = err_q | ((state_q == MWAIT) && (wait_q == WAIT_LIM));
      cnt_d = cnt_q;
      if (stall_if && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wait_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign stall_cnt   = cnt_q;
   assign err_timeout = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_ctrl;
   import riscv_pkg::*;

   localparam int MWAIT_MAX = 6;
   localparam int CNT_W     = 6;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic             clk, rst_n;
   logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic             ex_reg_wr, ex_is_load, mem_reg_wr, wb_reg_wr, br_taken;
   logic             stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic             err_timeout;
   state_e           dbg_state;

   hazard_ctrl_if mem_if ();

   hazard_ctrl #(.MWAIT_MAX(MWAIT_MAX), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .ex_rd       (ex_rd),
      .ex_reg_wr   (ex_reg_wr),
      .ex_is_load  (ex_is_load),
      .mem_rd      (mem_rd),
      .mem_reg_wr  (mem_reg_wr),
      .wb_rd       (wb_rd),
      .wb_reg_wr   (wb_reg_wr),
      .br_taken    (br_taken),
      .dmem_req    (mem_if.dmem_req),
      .dmem_ack    (mem_if.dmem_ack),
      .stall_if    (stall_if),
      .stall_id    (stall_id),
      .stall_ex    (stall_ex),
      .stall_mem   (stall_mem),
      .flush_id    (flush_id),
      .flush_ex    (flush_ex),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .stall_cnt   (stall_cnt),
      .err_timeout (err_timeout),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
      ex_reg_wr = 1'b0; ex_is_load = 1'b0; mem_reg_wr = 1'b0; wb_reg_wr = 1'b0;
      br_taken = 1'b0; mem_if.dmem_req = 1'b0; mem_if.dmem_ack = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic rand_inputs();
      id_rs1     = 5'($urandom_range(0, 7));
      id_rs2     = 5'($urandom_range(0, 7));
      ex_rd      = 5'($urandom_range(0, 7));
      mem_rd     = 5'($urandom_range(0, 7));
      wb_rd      = 5'($urandom_range(0, 7));
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_reg_wr  = ex_is_load | ($urandom_range(0, 1) == 1);
      mem_reg_wr = ($urandom_range(0, 1) == 1);
      wb_reg_wr  = ($urandom_range(0, 1) == 1);
      br_taken   = ($urandom_range(0, 5) == 0);
      mem_if.dmem_req = ($urandom_range(0, 2) == 0);
      mem_if.dmem_ack = ($urandom_range(0, 1) == 1);
   endtask

   // ---------------- behavioural model ----------------
   bit m_wait, m_bubble, m_err;
   int m_wcyc, m_cnt;

   function automatic bit src_hit(input logic [4:0] rs, input logic [4:0] rd, input logic wr);
      return wr && (rs != 5'd0) && (rs == rd);
   endfunction

   function automatic int exp_fwd(input logic [4:0] rs);
      if (!FWD_ON) return 0;
      if (src_hit(rs, mem_rd, mem_reg_wr)) return 1;
      if (src_hit(rs, wb_rd, wb_reg_wr)) return 2;
      return 0;
   endfunction

   function automatic bit hazard_now();
      if (FWD_ON)
         return src_hit(id_rs1, ex_rd, ex_is_load) || src_hit(id_rs2, ex_rd, ex_is_load);
      return src_hit(id_rs1, ex_rd, ex_reg_wr) || src_hit(id_rs2, ex_rd, ex_reg_wr)
          || src_hit(id_rs1, mem_rd, mem_reg_wr) || src_hit(id_rs2, mem_rd, mem_reg_wr)
          || src_hit(id_rs1, wb_rd, wb_reg_wr) || src_hit(id_rs2, wb_rd, wb_reg_wr);
   endfunction

   // ---------------- scoreboard: compare every cycle ----------------
   always @(negedge clk) begin
      int e_sf, e_sb, e_fid, e_fex, e_st;
      bit haz, mwait_in;
      if (!rst_n) begin
         m_wait = 1'b0; m_bubble = 1'b0; m_err = 1'b0; m_wcyc = 0; m_cnt = 0;
         chk("rst stall_if", int'(stall_if), 0);
         chk("rst stall_id", int'(stall_id), 0);
         chk("rst stall_ex", int'(stall_ex), 0);
         chk("rst stall_mem", int'(stall_mem), 0);
         chk("rst flush_id", int'(flush_id), 0);
         chk("rst flush_ex", int'(flush_ex), 0);
         chk("rst fwd_a", int'(fwd_a), 0);
         chk("rst fwd_b", int'(fwd_b), 0);
         chk("rst stall_cnt", int'(stall_cnt), 0);
         chk("rst err_timeout", int'(err_timeout), 0);
         chk("rst state", int'(dbg_state), int'(RUN));
      end else begin
         haz      = hazard_now();
         mwait_in = mem_if.dmem_req && !mem_if.dmem_ack;
         e_sf = 0; e_sb = 0; e_fid = 0; e_fex = 0; e_st = int'(RUN);
         if (m_wait) begin
            e_st = int'(MWAIT); e_sf = 1; e_sb = 1;
         end else begin
            if (m_bubble) e_st = int'(LSTALL);
            if (br_taken) begin e_fid = 1; e_fex = 1; end
            if (!m_bubble && !mwait_in && !br_taken && haz) begin e_sf = 1; e_fex = 1; end
         end
         chk("stall_if", int'(stall_if), e_sf);
         chk("stall_id", int'(stall_id), e_sf);
         chk("stall_ex", int'(stall_ex), e_sb);
         chk("stall_mem", int'(stall_mem), e_sb);
         chk("flush_id", int'(flush_id), e_fid);
         chk("flush_ex", int'(flush_ex), e_fex);
         chk("fwd_a", int'(fwd_a), exp_fwd(id_rs1));
         chk("fwd_b", int'(fwd_b), exp_fwd(id_rs2));
         chk("stall_cnt", int'(stall_cnt), m_cnt);
         chk("err_timeout", int'(err_timeout), int'(m_err));
         chk("state", int'(dbg_state), e_st);
         // advance the model across the coming clock edge
         if (e_sf == 1 && m_cnt < CNT_MAX) m_cnt++;
         if (m_wait) begin
            m_wcyc++;
            if (m_wcyc > MWAIT_MAX) m_err = 1'b1;
            if (mem_if.dmem_ack) m_wait = 1'b0;
         end else if (m_bubble) begin
            m_bubble = 1'b0;
         end else if (mwait_in) begin
            m_wait = 1'b1;
            m_wcyc = 0;
         end else if (haz && !br_taken && FWD_ON) begin
            m_bubble = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      idle();
      rst_n = 1'b0;
      cyc();
      #2;
      chk("por stall_cnt", int'(stall_cnt), 0);
      chk("por state", int'(dbg_state), int'(RUN));
      do_reset();

      // forwarding with MEM priority, then WB
      mem_rd = 5'd5; mem_reg_wr = 1'b1; wb_rd = 5'd5; wb_reg_wr = 1'b1; id_rs1 = 5'd5;
      #2;
      chk("fwd mem fwd_a", int'(fwd_a), FWD_ON ? 1 : 0);
      chk("fwd mem stall_if", int'(stall_if), FWD_ON ? 0 : 1);
      cyc();
      mem_reg_wr = 1'b0;
      #2;
      chk("fwd wb fwd_a", int'(fwd_a), FWD_ON ? 2 : 0);

      // load-use: one bubble, counter +1
      do_reset();
      ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
      #2;
      chk("lu stall_if", int'(stall_if), 1);
      chk("lu stall_id", int'(stall_id), 1);
      chk("lu flush_ex", int'(flush_ex), 1);
      cyc();
      idle();
      #2;
      chk("lu after stall_if", int'(stall_if), 0);
      chk("lu after stall_cnt", int'(stall_cnt), 1);
      chk("lu after state", int'(dbg_state), int'(FWD_ON ? LSTALL : RUN));
      cyc();
      #2;
      chk("lu done state", int'(dbg_state), int'(RUN));

      // x0 never hazards or forwards
      do_reset();
      ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
      #2;
      chk("x0 stall_if", int'(stall_if), 0);
      chk("x0 fwd_a", int'(fwd_a), 0);

      // memory wait: ack low for 3 cycles
      do_reset();
      mem_if.dmem_req = 1'b1; mem_if.dmem_ack = 1'b0;
      #2;
      chk("mw entry stall_if", int'(stall_if), 0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         #2;
         chk("mw stall_if", int'(stall_if), 1);
         chk("mw stall_mem", int'(stall_mem), 1);
      end
      cyc();
      mem_if.dmem_ack = 1'b1;
      #2;
      chk("mw ack stall_ex", int'(stall_ex), 1);
      cyc();
      idle();
      #2;
      chk("mw done stall_if", int'(stall_if), 0);
      chk("mw done stall_mem", int'(stall_mem), 0);
      chk("mw done state", int'(dbg_state), int'(RUN));
      chk("mw done stall_cnt", int'(stall_cnt), 3);

      // branch beats load-use
      do_reset();
      br_taken = 1'b1; ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
      #2;
      chk("br flush_id", int'(flush_id), 1);
      chk("br flush_ex", int'(flush_ex), 1);
      chk("br stall_if", int'(stall_if), 0);
      cyc();
      idle();
      #2;
      chk("br after state", int'(dbg_state), int'(RUN));
      chk("br after stall_cnt", int'(stall_cnt), 0);

      // reset in the middle of MWAIT
      do_reset();
      mem_if.dmem_req = 1'b1;
      cyc();
      mem_rd = 5'd3; mem_reg_wr = 1'b1; id_rs1 = 5'd3;
      cyc();
      cyc();
      #2;
      chk("rmw stall_cnt", int'(stall_cnt), 2);
      rst_n = 1'b0;
      #1;
      chk("rmw stall_if", int'(stall_if), 0);
      chk("rmw stall_mem", int'(stall_mem), 0);
      chk("rmw fwd_a", int'(fwd_a), 0);
      chk("rmw stall_cnt0", int'(stall_cnt), 0);
      chk("rmw state", int'(dbg_state), int'(RUN));
      cyc();
      idle();
      cyc();
      rst_n = 1'b1;
      mem_if.dmem_req = 1'b1; mem_if.dmem_ack = 1'b1;
      #2;
      chk("rmw zw stall_if", int'(stall_if), 0);
      cyc();
      idle();
      #2;
      chk("rmw zw state", int'(dbg_state), int'(RUN));

      // timeout: err after MWAIT_MAX+1 wait cycles, branch ignored while waiting
      do_reset();
      mem_if.dmem_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         br_taken = (k == 2);
         #2;
         if (k == 2) chk("to br flush_id", int'(flush_id), 0);
         if (k == 7) chk("to err early", int'(err_timeout), 0);
         if (k == 8) chk("to err set", int'(err_timeout), 1);
      end
      cyc();
      br_taken = 1'b0;
      mem_if.dmem_ack = 1'b1;
      cyc();
      idle();
      #2;
      chk("to sticky err", int'(err_timeout), 1);
      chk("to state", int'(dbg_state), int'(RUN));

      // stall counter saturates
      do_reset();
      mem_if.dmem_req = 1'b1;
      repeat (70) cyc();
      #2;
      chk("sat stall_cnt", int'(stall_cnt), CNT_MAX);
      mem_if.dmem_ack = 1'b1;
      cyc();
      idle();
      cyc();
      #2;
      chk("sat hold stall_cnt", int'(stall_cnt), CNT_MAX);

      // randomized traffic with occasional resets
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         cyc();
         rand_inputs();
         rst_n = ($urandom_range(0, 99) != 0);
      end
      cyc();
      rst_n = 1'b1;
      idle();
      repeat (4) cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
